// File: rtl/pwm_pkg.sv
// Shared encodings for the multi-channel PWM block.
package pwm_pkg;
  localparam logic PWM_EDGE   = 1'b0;
  localparam logic PWM_CENTER = 1'b1;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;
endpackage

// File: rtl/pwm_timebase.sv
// Shared prescaler and up/down period counter; flags period boundaries and
// marks the first output cycle of each period.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [WIDTH-1:0]      period,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  center,
  output logic [WIDTH-1:0]      count,
  output logic                  load,
  output logic                  period_start
);

  logic [PRESCALE_W-1:0] pcnt;
  logic [WIDTH-1:0]      p_lat;
  logic [WIDTH-1:0]      top;
  logic                  mode_lat;
  logic                  en_prev;
  logic                  start_d;
  logic                  tick;
  logic                  at_bnd;
  dir_e                  dir;

  always_comb begin
    // >= keeps the divider from running the long way round if D shrinks mid-count
    tick = (pcnt >= prescale);
    // center mode treats P = 0 as P = 1, so the turn-around point is 0
    top  = (p_lat == '0) ? '0 : p_lat - WIDTH'(1);
    if (mode_lat == PWM_EDGE) at_bnd = (count == p_lat);
    else                      at_bnd = (dir == DIR_DOWN) && (count == '0);
    load = !enable || (tick && at_bnd);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt         <= '0;
      count        <= '0;
      dir          <= DIR_UP;
      p_lat        <= '0;
      mode_lat     <= PWM_EDGE;
      en_prev      <= 1'b0;
      start_d      <= 1'b0;
      period_start <= 1'b0;
    end else if (!enable) begin
      pcnt         <= '0;
      count        <= '0;
      dir          <= DIR_UP;
      p_lat        <= period;
      mode_lat     <= center;
      en_prev      <= 1'b0;
      start_d      <= 1'b0;
      period_start <= 1'b0;
    end else begin
      en_prev      <= 1'b1;
      // the output register lags count by one clk, hence the extra stage
      start_d      <= tick && at_bnd;
      period_start <= start_d || !en_prev;
      pcnt         <= tick ? '0 : pcnt + 1'b1;
      if (tick) begin
        if (at_bnd) begin
          count    <= '0;
          dir      <= DIR_UP;
          p_lat    <= period;
          mode_lat <= center;
        end else if (mode_lat == PWM_EDGE) begin
          count <= count + 1'b1;
        end else if (dir == DIR_UP) begin
          if (count == top) dir <= DIR_DOWN;
          else              count <= count + 1'b1;
        end else begin
          count <= count - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: one shared timebase, per-channel double-buffered levels,
// comparators and optional output inversion.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int                  WIDTH      = 8,
  parameter int                  CHANNELS   = 4,
  parameter int                  PRESCALE_W = 8,
  parameter logic [CHANNELS-1:0] INVERT     = {CHANNELS{1'b0}}
) (
  input  logic                                            clk,
  input  logic                                            reset,
  input  logic                                            enable,
  input  logic [WIDTH-1:0]                                period,
  input  logic [PRESCALE_W-1:0]                           prescale,
  input  logic                                            center,
  input  logic                                            level_wr,
  input  logic [(CHANNELS > 1 ? $clog2(CHANNELS) : 1)-1:0] level_sel,
  input  logic [WIDTH-1:0]                                level_data,
  output logic [CHANNELS-1:0]                             out,
  output logic                                            period_start
);

  localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [WIDTH-1:0] count;
  logic             load;

  pwm_timebase #(
    .WIDTH      (WIDTH),
    .PRESCALE_W (PRESCALE_W)
  ) u_timebase (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .period       (period),
    .prescale     (prescale),
    .center       (center),
    .count        (count),
    .load         (load),
    .period_start (period_start)
  );

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [WIDTH-1:0] shadow;
    logic [WIDTH-1:0] active;
    logic             hit;
    logic             o_q;

    assign hit    = level_wr && (level_sel == SEL_W'(i));
    assign out[i] = o_q;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        shadow <= '0;
        active <= '0;
        o_q    <= INVERT[i];
      end else begin
        if (hit) shadow <= level_data;
        // a write landing on the boundary tick goes straight to the active level
        if (load) active <= hit ? level_data : shadow;
        o_q <= enable ? ((count < active) ^ INVERT[i]) : INVERT[i];
      end
    end
  end

endmodule

// File: tb/tb_pwm_multi.sv
// Directed bench for pwm_multi: vector table of per-period duty measurements
// plus hand-written sequences for reset, double buffering, config and enable.
module tb_pwm_multi;
  localparam int W = 8, CH = 4, PW = 8;
  localparam logic [CH-1:0] INV = 4'b0010;

  logic          clk = 1'b0;
  logic          reset, enable, center, level_wr, period_start;
  logic [W-1:0]  period, level_data;
  logic [PW-1:0] prescale;
  logic [1:0]    level_sel;
  logic [CH-1:0] out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pwm_multi #(.WIDTH(W), .CHANNELS(CH), .PRESCALE_W(PW), .INVERT(INV)) dut (
    .clk(clk), .reset(reset), .enable(enable), .period(period),
    .prescale(prescale), .center(center), .level_wr(level_wr),
    .level_sel(level_sel), .level_data(level_data), .out(out),
    .period_start(period_start)
  );

  typedef struct {
    int p; int d; bit c; int l[4]; int n; int hi[4];
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic write_level(input int sel, input int data);
    level_sel  = 2'(sel);
    level_data = W'(data);
    level_wr   = 1'b1;
    @(negedge clk);
    level_wr   = 1'b0;
  endtask

  task automatic wait_ps(output bit ok);
    int n = 0;
    while (!period_start && n < 2000) begin
      @(negedge clk);
      n++;
    end
    ok = period_start;
  endtask

  task automatic cfg(input int p, input int d, input bit c, input int l[4]);
    enable = 1'b0;
    @(negedge clk);
    period   = W'(p);
    prescale = PW'(d);
    center   = c;
    for (int i = 0; i < 4; i++) write_level(i, l[i]);
    @(negedge clk);
    enable = 1'b1;
  endtask

  // measure one full period starting at a period_start; e[c] < 0 skips channel c
  task automatic measure(input string name, input int n, input int e[4]);
    bit ok;
    int k;
    int hi[4];
    wait_ps(ok);
    chk({name, "_ps_seen"}, int'(ok), 1);
    if (!ok) return;
    hi = '{0, 0, 0, 0};
    k = 0;
    do begin
      for (int c = 0; c < 4; c++) hi[c] += int'(out[c]);
      @(negedge clk);
      k++;
    end while (!period_start && k < 2000);
    chk({name, "_spacing"}, k, n);
    for (int c = 0; c < 4; c++)
      if (e[c] >= 0) chk($sformatf("%s_hi%0d", name, c), hi[c], e[c]);
  endtask

  initial begin
    bit ok;
    int hi;
    int e4[4];
    int l4[4];
    int pat_o[10];
    int pat_p[10];

    reset = 1'b1; enable = 1'b0; center = 1'b0; level_wr = 1'b0;
    level_sel = '0; level_data = '0; period = '0; prescale = '0;

    vecs[0] = '{4,   0, 1'b0, '{2, 0, 4, 5},      5,   '{2, 5, 4, 5}};
    vecs[1] = '{9,   0, 1'b0, '{0, 5, 10, 255},   10,  '{0, 5, 10, 10}};
    vecs[2] = '{3,   2, 1'b1, '{2, 0, 3, 9},      18,  '{12, 18, 18, 18}};
    vecs[3] = '{0,   1, 1'b1, '{0, 1, 2, 0},      4,   '{0, 0, 4, 0}};
    vecs[4] = '{255, 0, 1'b0, '{128, 255, 1, 0},  256, '{128, 1, 1, 0}};
    vecs[5] = '{5,   3, 1'b0, '{3, 6, 7, 1},      24,  '{12, 0, 24, 4}};
    vecs[6] = '{4,   0, 1'b1, '{1, 2, 4, 5},      8,   '{2, 4, 8, 8}};

    #3;
    chk("reset_out", int'(out), int'(INV));
    chk("reset_ps", int'(period_start), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      cfg(vecs[v].p, vecs[v].d, vecs[v].c, vecs[v].l);
      measure($sformatf("vec%0d", v), vecs[v].n, vecs[v].hi);
    end

    // asynchronous reset between clock edges while running
    wait_ps(ok);
    #1 reset = 1'b1;
    #1;
    chk("midrst_out", int'(out), int'(INV));
    chk("midrst_ps", int'(period_start), 0);
    enable = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    l4 = '{2, 0, 0, 0};
    cfg(4, 0, 1'b0, l4);
    wait_ps(ok);
    pat_o = '{1, 1, 0, 0, 0, 1, 1, 0, 0, 0};
    pat_p = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("rst_seq%0d", k), int'({period_start, out[0]}), pat_p[k] * 2 + pat_o[k]);
      @(negedge clk);
    end

    // double buffering: mid-period write waits, boundary write goes through
    l4 = '{2, 0, 0, 0};
    cfg(7, 0, 1'b0, l4);
    wait_ps(ok);
    hi = 0;
    for (int k = 0; k < 8; k++) begin
      if (k == 2) begin level_sel = 2'd0; level_data = 8'd6; level_wr = 1'b1; end
      if (k == 3) level_wr = 1'b0;
      hi += int'(out[0]);
      @(negedge clk);
    end
    chk("db_old_hi", hi, 2);
    chk("db_old_ps", int'(period_start), 1);
    hi = 0;
    for (int k = 0; k < 8; k++) begin
      if (k == 6) begin level_sel = 2'd0; level_data = 8'd3; level_wr = 1'b1; end
      if (k == 7) level_wr = 1'b0;
      hi += int'(out[0]);
      @(negedge clk);
    end
    chk("db_new_hi", hi, 6);
    e4 = '{3, -1, -1, -1};
    measure("db_bnd", 8, e4);

    // period/mode change mid-period applies only from the next boundary
    hi = 0;
    for (int k = 0; k < 8; k++) begin
      if (k == 2) begin period = 8'd3; center = 1'b1; end
      hi += int'(out[0]);
      @(negedge clk);
    end
    chk("cfg_old_hi", hi, 3);
    chk("cfg_old_ps", int'(period_start), 1);
    e4 = '{6, -1, -1, -1};
    measure("cfg_new", 6, e4);

    // enable toggle
    enable = 1'b0;
    @(negedge clk);
    chk("dis_out", int'(out), int'(INV));
    chk("dis_ps", int'(period_start), 0);
    write_level(0, 1);
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    chk("en_ps", int'(period_start), 1);
    chk("en_out0", int'(out[0]), 1);
    e4 = '{2, -1, -1, -1};
    measure("en", 6, e4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
